conv_downsize: RTL and testbench
================================

CONV_DOWNSIZE -- requirements
Module: conv_downsize

Interface
REQ-001 SHALL have parameter IN_W, default 32, input word width in bits.
REQ-002 SHALL have parameter OUT_W, default 8, output lane width in bits.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = most-significant lane emitted first, 0 = least-significant lane first.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_data, input, IN_W, wide word.
REQ-007 SHALL have port in_valid, input, 1, in_data valid.
REQ-008 SHALL have port in_ready, output, 1, block can accept a word this cycle.
REQ-009 SHALL have port out_data, output, OUT_W, current lane.
REQ-010 SHALL have port out_valid, output, 1, out_data valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the lane.
REQ-012 SHALL have port words_done, output, 16, count of fully emitted words, wrapping.

Function
REQ-013 SHALL define RATIO = IN_W/OUT_W; elaboration SHALL fail if IN_W mod OUT_W != 0 or RATIO < 2.
REQ-014 SHALL hold a word register, lane counter (clog2(RATIO) bits) and busy flag; two states: IDLE (busy=0) and SHIFT (busy=1).
REQ-015 SHALL transfer on in_valid && in_ready: load the word register, zero the lane counter, enter SHIFT.
REQ-016 SHALL drive out_valid = busy; first lane valid the cycle after acceptance (latency 1).
REQ-017 With MSB_FIRST=1, lane k SHALL be in_data[IN_W-1-k*OUT_W -: OUT_W]; with MSB_FIRST=0, in_data[k*OUT_W +: OUT_W].
REQ-018 On out_valid && out_ready SHALL advance the lane counter; out_data and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-019 in_ready SHALL be (!busy) || (out_valid && out_ready && lane==RATIO-1), combinational, so back-to-back words stream without bubbles: one word per RATIO cycles with out_ready held high.
REQ-020 On the last-lane handshake with a simultaneous input transfer, SHALL load the new word and stay in SHIFT; without one, SHALL return to IDLE.
REQ-021 words_done SHALL increment by 1 on every last-lane handshake, wrapping 0xFFFF -> 0x0000.
REQ-022 in_valid while in_ready=0 SHALL be ignored; upstream holds the word (no data loss).

Reset
REQ-023 While reset=1: busy=0, lane=0, word register=0, out_valid=0, out_data=0, words_done=0, in_ready=0.
REQ-024 Reset asserted mid-word SHALL discard the partial word; the first cycle after deassertion SHALL show in_ready=1, out_valid=0.

Configuration
REQ-025 Macro CONV_DOWNSIZE_LAST_EN: when defined, SHALL add input in_last (1) and output out_last (1); in_last is captured with the word, and out_last=1 only on that word's final lane (lane==RATIO-1), else 0; reset value 0.
REQ-026 Without CONV_DOWNSIZE_LAST_EN, in_last/out_last SHALL not exist and behaviour is otherwise identical.

Structure
REQ-027 Package conv_pkg SHALL hold the default widths, the 16-bit words_done width constant and the state encoding (IDLE, SHIFT).
REQ-028 Lane selection SHALL be a sub-module conv_lane_sel (word, lane index, MSB_FIRST -> lane); combinational only; the FSM, counters and handshake SHALL reside in conv_downsize.

Verification
REQ-029 Single word: IN_W=32, OUT_W=8, MSB_FIRST=1, in_data=0xA1B2C3D4, out_ready=1 -> out_data A1,B2,C3,D4 on 4 consecutive cycles starting 1 cycle after acceptance; words_done=1.
REQ-030 Lane order: same word, MSB_FIRST=0 -> D4,C3,B2,A1.
REQ-031 Streaming: 3 words 0x00010203, 0x04050607, 0x08090A0B with in_valid=1, out_ready=1 -> 12 lanes 00..0B with no gaps; in_ready=1 only on the last-lane cycles after the first accept; words_done=3.
REQ-032 Backpressure: out_ready=0 for 5 cycles during lane 1 of 0x11223344 -> out_data held at 0x22, out_valid=1, in_ready=0; resume -> 33,44.
REQ-033 Reset mid-word: assert reset after lane 0x11 of 0x11223344 -> out_valid=0 and words_done=0 immediately; after release a new word 0xDEADBEEF emits DE,AD,BE,EF.
REQ-034 With CONV_DOWNSIZE_LAST_EN, in_last=1 on 0xCAFEF00D -> out_last=1 only with lane 0x0D; 0 for every lane of a following word with in_last=0.

Source files
------------

// File: rtl/conv_pkg.sv
// ============================================================================
// conv_pkg : shared widths and state encoding for the conv_downsize slice
// Revision : 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int CONV_DEF_IN_W  = 32;
    localparam int CONV_DEF_OUT_W = 8;
    localparam int WORDS_DONE_W   = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/conv_lane_sel.sv
// ============================================================================
// conv_lane_sel : combinational pick of one OUT_W lane out of an IN_W word
// Revision      : 1.0
// ============================================================================
`default_nettype none

module conv_lane_sel #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter int MSB_FIRST = 1,
    parameter int RATIO     = IN_W / OUT_W,
    parameter int LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic [IN_W-1:0]   word_i,
    input  logic [LANE_W-1:0] lane_i,
    output logic [OUT_W-1:0]  lane_o
);

    // Lane k is pre-sliced in emission order so the runtime select is a plain mux.
    logic [OUT_W-1:0] w_lanes [RATIO];

    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        if (MSB_FIRST != 0) begin : g_msb
            assign w_lanes[k] = word_i[IN_W-1-k*OUT_W -: OUT_W];
        end else begin : g_lsb
            assign w_lanes[k] = word_i[k*OUT_W +: OUT_W];
        end
    end

    assign lane_o = w_lanes[lane_i];

endmodule

`default_nettype wire

// File: rtl/conv_downsize.sv
// ============================================================================
// conv_downsize : width down-converter, one IN_W word -> RATIO OUT_W lanes
// Optional macro CONV_DOWNSIZE_LAST_EN adds in_last / out_last framing.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module conv_downsize
    import conv_pkg::*;
#(
    parameter int IN_W      = CONV_DEF_IN_W,
    parameter int OUT_W     = CONV_DEF_OUT_W,
    parameter int MSB_FIRST = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IN_W-1:0]         in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORDS_DONE_W-1:0] words_done
`ifdef CONV_DOWNSIZE_LAST_EN
    ,
    input  logic                    in_last,
    output logic                    out_last
`endif
);

    localparam int RATIO  = IN_W / OUT_W;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    if (((IN_W % OUT_W) != 0) || (RATIO < 2)) begin : g_bad_ratio
        $error("conv_downsize: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
    end

    state_e                  state_q, state_d;
    logic [IN_W-1:0]         word_q, word_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [WORDS_DONE_W-1:0] done_q, done_d;

    logic             w_busy;
    logic             w_out_hs;
    logic             w_at_last;
    logic             w_in_hs;
    logic [OUT_W-1:0] w_lane_data;

    assign w_busy    = (state_q == SHIFT);
    assign w_out_hs  = w_busy && out_ready;
    assign w_at_last = (lane_q == LAST_LANE);
    // Reopening on the last-lane handshake lets words stream with no bubble.
    assign in_ready  = !reset && (!w_busy || (w_out_hs && w_at_last));
    assign w_in_hs   = in_valid && in_ready;

    assign out_valid  = w_busy;
    assign out_data   = w_busy ? w_lane_data : '0;
    assign words_done = done_q;

    conv_lane_sel #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .MSB_FIRST (MSB_FIRST),
        .RATIO     (RATIO),
        .LANE_W    (LANE_W)
    ) u_lane_sel (
        .word_i (word_q),
        .lane_i (lane_q),
        .lane_o (w_lane_data)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        lane_d  = lane_q;
        done_d  = done_q;

        if (w_out_hs && w_at_last) begin
            done_d  = done_q + 1'b1;
            state_d = IDLE;
        end else if (w_out_hs) begin
            lane_d = lane_q + 1'b1;
        end

        // A new word overrides the return to IDLE on the last-lane cycle.
        if (w_in_hs) begin
            word_d  = in_data;
            lane_d  = '0;
            state_d = SHIFT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            lane_q  <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            done_q  <= done_d;
        end
    end

`ifdef CONV_DOWNSIZE_LAST_EN
    logic last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b0;
        end else if (w_in_hs) begin
            last_q <= in_last;
        end
    end

    assign out_last = w_busy && last_q && w_at_last;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_downsize.sv
// ============================================================================
// tb_conv_downsize : directed + random bench for conv_downsize (MSB and LSB order)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_conv_downsize;

    localparam int IN_W  = 32;
    localparam int OUT_W = 8;
    localparam int RATIO = IN_W / OUT_W;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic [7:0]  out_data_m, out_data_l;
    logic        out_valid_m, out_valid_l;
    logic        in_ready_m, in_ready_l;
    logic [15:0] done_m, done_l;
    logic        out_last_m, out_last_l;

    always #5 clk = ~clk;

    conv_downsize #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1)) dut_m (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready_m),
        .out_data   (out_data_m),
        .out_valid  (out_valid_m),
        .out_ready  (out_ready),
        .words_done (done_m)
`ifdef CONV_DOWNSIZE_LAST_EN
        ,
        .in_last    (in_last),
        .out_last   (out_last_m)
`endif
    );

    conv_downsize #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(0)) dut_l (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready_l),
        .out_data   (out_data_l),
        .out_valid  (out_valid_l),
        .out_ready  (out_ready),
        .words_done (done_l)
`ifdef CONV_DOWNSIZE_LAST_EN
        ,
        .in_last    (in_last),
        .out_last   (out_last_l)
`endif
    );

    // Reference: queue of lanes still owed for the current word.
    typedef struct {
        logic [7:0] m;
        logic [7:0] l;
        logic       last;
    } lane_t;

    lane_t       q[$];
    logic [15:0] exp_done = 16'd0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic lst);
        for (int k = 0; k < RATIO; k++) begin
            lane_t e;
            e.m    = 8'((d >> (OUT_W * (RATIO - 1 - k))) & 32'hFF);
            e.l    = 8'((d >> (OUT_W * k)) & 32'hFF);
            e.last = lst && (k == RATIO - 1);
            q.push_back(e);
        end
    endtask

    task automatic check_outputs();
        logic ev;
        logic er;
        ev = (q.size() > 0);
        er = (q.size() == 0) || ((q.size() == 1) && out_ready);
        chk("out_valid_m", 32'(out_valid_m), 32'(ev));
        chk("out_valid_l", 32'(out_valid_l), 32'(ev));
        chk("in_ready_m", 32'(in_ready_m), 32'(er));
        chk("in_ready_l", 32'(in_ready_l), 32'(er));
        chk("words_done_m", 32'(done_m), 32'(exp_done));
        chk("words_done_l", 32'(done_l), 32'(exp_done));
        if (ev) begin
            chk("out_data_m", 32'(out_data_m), 32'(q[0].m));
            chk("out_data_l", 32'(out_data_l), 32'(q[0].l));
        end
`ifdef CONV_DOWNSIZE_LAST_EN
        chk("out_last_m", 32'(out_last_m), 32'(ev ? q[0].last : 1'b0));
        chk("out_last_l", 32'(out_last_l), 32'(ev ? q[0].last : 1'b0));
`endif
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic v, input logic [31:0] d, input logic lst,
                        input logic r, output logic acc);
        logic er;
        in_valid  = v;
        in_data   = d;
        in_last   = lst;
        out_ready = r;
        #1;
        check_outputs();
        er  = (q.size() == 0) || ((q.size() == 1) && r);
        acc = v && er;
        @(posedge clk);
        if ((q.size() > 0) && r) begin
            if (q.size() == 1) exp_done++;
            void'(q.pop_front());
        end
        if (acc) push_word(d, lst);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic lst);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 64 && !acc; i++) step(1'b1, d, lst, 1'b1, acc);
        if (!acc) begin
            n_bad++;
            $error("FAIL send_timeout: observed no accept, expected accept of 0x%0h", d);
        end
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 64 && q.size() > 0; i++) step(1'b0, 32'h0, 1'b0, 1'b1, acc);
        if (q.size() > 0) begin
            n_bad++;
            $error("FAIL drain_timeout: observed %0d lanes left, expected 0", q.size());
        end
        step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid_m", 32'(out_valid_m), 32'd0);
        chk("rst_out_valid_l", 32'(out_valid_l), 32'd0);
        chk("rst_out_data_m", 32'(out_data_m), 32'd0);
        chk("rst_out_data_l", 32'(out_data_l), 32'd0);
        chk("rst_in_ready_m", 32'(in_ready_m), 32'd0);
        chk("rst_in_ready_l", 32'(in_ready_l), 32'd0);
        chk("rst_words_done_m", 32'(done_m), 32'd0);
        chk("rst_words_done_l", 32'(done_l), 32'd0);
`ifdef CONV_DOWNSIZE_LAST_EN
        chk("rst_out_last_m", 32'(out_last_m), 32'd0);
`endif
    endtask

    initial begin
        logic acc;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;

        // Single word, both lane orders
        send_word(32'hA1B2C3D4, 1'b0);
        drain();
        chk("single_words_done", 32'(done_m), 32'd1);

        // Three back-to-back words
        send_word(32'h00010203, 1'b0);
        send_word(32'h04050607, 1'b0);
        send_word(32'h08090A0B, 1'b0);
        drain();
        chk("stream_words_done", 32'(done_m), 32'd4);

        // Backpressure on lane 1
        send_word(32'h11223344, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, acc);
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0, acc);
        drain();

        // Reset mid-word after lane 0x11
        send_word(32'h11223344, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, acc);
        reset = 1'b1;
        #1;
        check_reset_state();
        q.delete();
        exp_done = 16'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_word(32'hDEADBEEF, 1'b0);
        drain();

`ifdef CONV_DOWNSIZE_LAST_EN
        send_word(32'hCAFEF00D, 1'b1);
        send_word(32'h12345678, 1'b0);
        drain();
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), acc);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
